// File: rtl/dram_line_reader.sv
// Fetches frame lines from DRAM, one row per line, into two ping-pong line buffers.
// Ports: CLK100MHz/reset; frameStart/lineReq control; DRAM read handshake + data;
//        buffer write strobes/data; readBuffSelect, lineReady, frameDone, overrun status.
module dram_line_reader #(
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 480
) (
    input  logic        CLK100MHz,
    input  logic        reset,
    input  logic        frameStart,
    input  logic        lineReq,
    input  logic        DRAMReadAck,
    input  logic        DRAMReadValid,
    input  logic [15:0] dataFromDRAM,
    output logic        DRAMReadReq,
    output logic [12:0] rowAddress,
    output logic [1:0]  bankAddress,
    output logic        outBuffWr1,
    output logic        outBuffWr2,
    output logic [15:0] dataToBuff,
    output logic        readBuffSelect,
    output logic        lineReady,
    output logic        frameDone,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, REQ, READ, DONE, HALT} state_t;

    localparam logic [9:0]  LAST_PIX = 10'(LINE_PIXELS - 1);
    localparam logic [12:0] LAST_ROW = 13'(FRAME_LINES - 1);

    state_t      state, stateNext;
    logic        fillSel, fillSelNext;
    logic [9:0]  pixelCount, pixelCountNext;
    logic        pending, pendingNext;
    logic        readReqNext;
    logic        wr1Next, wr2Next;
    logic [15:0] dataNext;
    logic [12:0] rowNext;
    logic        selNext;
    logic        lineReadyNext, frameDoneNext, overrunNext;

    assign bankAddress = 2'b00;

    always_ff @(posedge CLK100MHz or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            fillSel        <= 1'b0;
            pixelCount     <= '0;
            pending        <= 1'b0;
            DRAMReadReq    <= 1'b0;
            outBuffWr1     <= 1'b0;
            outBuffWr2     <= 1'b0;
            dataToBuff     <= '0;
            rowAddress     <= '0;
            readBuffSelect <= 1'b0;
            lineReady      <= 1'b0;
            frameDone      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= stateNext;
            fillSel        <= fillSelNext;
            pixelCount     <= pixelCountNext;
            pending        <= pendingNext;
            DRAMReadReq    <= readReqNext;
            outBuffWr1     <= wr1Next;
            outBuffWr2     <= wr2Next;
            dataToBuff     <= dataNext;
            rowAddress     <= rowNext;
            readBuffSelect <= selNext;
            lineReady      <= lineReadyNext;
            frameDone      <= frameDoneNext;
            overrun        <= overrunNext;
        end
    end

    always_comb begin
        stateNext      = state;
        fillSelNext    = fillSel;
        pixelCountNext = pixelCount;
        pendingNext    = pending;
        readReqNext    = DRAMReadReq;
        wr1Next        = 1'b0;
        wr2Next        = 1'b0;
        dataNext       = dataToBuff;
        rowNext        = rowAddress;
        selNext        = readBuffSelect;
        lineReadyNext  = 1'b0;
        frameDoneNext  = 1'b0;
        overrunNext    = overrun;

        if (frameStart) begin
            stateNext      = REQ;
            readReqNext    = 1'b0;
            rowNext        = '0;
            pixelCountNext = '0;
            pendingNext    = 1'b0;
            overrunNext    = 1'b0;
            fillSelNext    = 1'b0;
            selNext        = 1'b0;
        end else begin
            // Only one request can be queued behind the line in flight.
            if (lineReq && (state == REQ || state == READ || state == DONE)) begin
                if (pending)
                    overrunNext = 1'b1;
                else
                    pendingNext = 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (pending) begin
                        // A fresh lineReq here re-queues while the old one is serviced.
                        pendingNext = lineReq;
                        stateNext   = REQ;
                    end else if (lineReq) begin
                        stateNext = REQ;
                    end
                end
                REQ: begin
                    readReqNext = 1'b1;
                    if (DRAMReadAck) begin
                        stateNext      = READ;
                        pixelCountNext = '0;
                    end
                end
                READ: begin
                    if (DRAMReadValid) begin
                        dataNext       = dataFromDRAM;
                        wr1Next        = !fillSel;
                        wr2Next        = fillSel;
                        pixelCountNext = pixelCount + 10'd1;
                        if (pixelCount == LAST_PIX) begin
                            stateNext   = DONE;
                            readReqNext = 1'b0;
                        end
                    end
                end
                DONE: begin
                    selNext       = fillSel;
                    fillSelNext   = ~fillSel;
                    lineReadyNext = 1'b1;
                    rowNext       = rowAddress + 13'd1;
                    if (rowAddress == LAST_ROW) begin
                        frameDoneNext = 1'b1;
                        stateNext     = HALT;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                HALT: begin
                end
                default: stateNext = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_line_reader.sv
// Directed self-checking bench for dram_line_reader.
// Frame height is shortened so a whole frame fits in a short run.
module tb_dram_line_reader;

    localparam int LP = 640;
    localparam int FL = 16;

    logic        CLK100MHz = 1'b0;
    logic        reset;
    logic        frameStart;
    logic        lineReq;
    logic        DRAMReadAck;
    logic        DRAMReadValid;
    logic [15:0] dataFromDRAM;
    logic        DRAMReadReq;
    logic [12:0] rowAddress;
    logic [1:0]  bankAddress;
    logic        outBuffWr1;
    logic        outBuffWr2;
    logic [15:0] dataToBuff;
    logic        readBuffSelect;
    logic        lineReady;
    logic        frameDone;
    logic        overrun;

    int checks   = 0;
    int failures = 0;
    int expRow   = 0;
    int waited;

    dram_line_reader #(.LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
        .CLK100MHz     (CLK100MHz),
        .reset         (reset),
        .frameStart    (frameStart),
        .lineReq       (lineReq),
        .DRAMReadAck   (DRAMReadAck),
        .DRAMReadValid (DRAMReadValid),
        .dataFromDRAM  (dataFromDRAM),
        .DRAMReadReq   (DRAMReadReq),
        .rowAddress    (rowAddress),
        .bankAddress   (bankAddress),
        .outBuffWr1    (outBuffWr1),
        .outBuffWr2    (outBuffWr2),
        .dataToBuff    (dataToBuff),
        .readBuffSelect(readBuffSelect),
        .lineReady     (lineReady),
        .frameDone     (frameDone),
        .overrun       (overrun)
    );

    always #5 CLK100MHz = ~CLK100MHz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        fs;
        logic        ack;
        logic        vld;
        logic [15:0] din;
        logic        expReq;
        logic        expWr1;
        logic        expWr2;
        logic [15:0] expData;
        logic [12:0] expRow;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idleIn();
        frameStart    = 1'b0;
        lineReq       = 1'b0;
        DRAMReadAck   = 1'b0;
        DRAMReadValid = 1'b0;
        dataFromDRAM  = 16'h0;
    endtask

    task automatic step();
        @(posedge CLK100MHz);
        #1;
    endtask

    function automatic logic [63:0] allOut();
        return {26'h0, DRAMReadReq, rowAddress, bankAddress, outBuffWr1,
                outBuffWr2, dataToBuff, readBuffSelect, lineReady,
                frameDone, overrun};
    endfunction

    task automatic doLine(input bit gapped, input int lrA, input int lrB,
                          output int wt);
        logic        sel;
        int          wr1n, wr2n, badData, reqDrop, overlap;
        logic [15:0] d, lastD;
        sel = ((expRow % 2) == 1);
        wr1n = 0; wr2n = 0; badData = 0; reqDrop = 0; overlap = 0;
        wt = 0;
        idleIn();
        while (!DRAMReadReq && wt < 10) begin
            step();
            wt++;
        end
        check("reqWait", DRAMReadReq, 1);
        DRAMReadAck = 1'b1;
        step();
        idleIn();
        lastD = dataToBuff;
        for (int w = 0; w < LP; w++) begin
            if (gapped) begin
                DRAMReadValid = 1'b0;
                dataFromDRAM  = 16'hDEAD;
                step();
                if (outBuffWr1 || outBuffWr2) overlap++;
                if (dataToBuff !== lastD) badData++;
            end
            d = 16'(w + expRow * 7);
            DRAMReadValid = 1'b1;
            dataFromDRAM  = d;
            lineReq       = (w == lrA || w == lrB);
            step();
            idleIn();
            if (outBuffWr1 && outBuffWr2) overlap++;
            if (outBuffWr1) wr1n++;
            if (outBuffWr2) wr2n++;
            if (dataToBuff !== d) badData++;
            lastD = d;
            if (w < LP - 1 && !DRAMReadReq) reqDrop++;
        end
        check("wr1Count", wr1n, sel ? 0 : LP);
        check("wr2Count", wr2n, sel ? LP : 0);
        check("badData", badData, 0);
        check("badStrobe", overlap, 0);
        check("reqHeld", reqDrop, 0);
        check("reqDropAtEnd", DRAMReadReq, 0);
        check("readyEarly", lineReady, 0);
        step();
        expRow++;
        check("lineReady", lineReady, 1);
        check("readSel", readBuffSelect, sel);
        check("rowAddr", rowAddress, expRow);
        check("frameDone", frameDone, (expRow == FL));
    endtask

    initial begin
        int n2;
        idleIn();
        reset = 1'b1;
        #12;
        check("resetOut", allOut(), 0);
        @(negedge CLK100MHz);
        reset = 1'b0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 13'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0, 13'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0, 13'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 13'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0, 13'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h0, 13'd0};

        for (int i = 0; i < 6; i++) begin
            frameStart    = vecs[i].fs;
            DRAMReadAck   = vecs[i].ack;
            DRAMReadValid = vecs[i].vld;
            dataFromDRAM  = vecs[i].din;
            step();
            idleIn();
            check($sformatf("vec%0d", i),
                  {32'h0, DRAMReadReq, outBuffWr1, outBuffWr2, dataToBuff, rowAddress},
                  {32'h0, vecs[i].expReq, vecs[i].expWr1, vecs[i].expWr2,
                   vecs[i].expData, vecs[i].expRow});
        end

        expRow = 0;
        doLine(1'b0, -1, -1, waited);
        step();
        check("idleNoReq", DRAMReadReq, 0);

        lineReq = 1'b1;
        step();
        idleIn();
        doLine(1'b1, -1, -1, waited);

        lineReq = 1'b1;
        step();
        idleIn();
        doLine(1'b0, 100, 200, waited);
        check("overrunSet", overrun, 1);

        doLine(1'b0, -1, -1, waited);
        check("queuedNoGap", waited, 2);
        check("overrunSticky", overrun, 1);

        lineReq = 1'b1;
        step();
        idleIn();
        doLine(1'b0, -1, -1, waited);

        lineReq = 1'b1;
        step();
        idleIn();
        step();
        DRAMReadAck = 1'b1;
        step();
        idleIn();
        n2 = 0;
        for (int w = 0; w < 300; w++) begin
            DRAMReadValid = 1'b1;
            dataFromDRAM  = 16'(w + 35);
            step();
            idleIn();
            if (outBuffWr2 && !outBuffWr1) n2++;
        end
        check("partialWr2", n2, 300);
        frameStart    = 1'b1;
        DRAMReadValid = 1'b1;
        dataFromDRAM  = 16'hBEEF;
        step();
        idleIn();
        check("restartOut",
              {DRAMReadReq, outBuffWr1, outBuffWr2, rowAddress, overrun,
               readBuffSelect, lineReady}, 0);
        expRow = 0;
        doLine(1'b0, -1, -1, waited);

        for (int n = 1; n < FL; n++) begin
            lineReq = 1'b1;
            step();
            idleIn();
            doLine(1'b0, -1, -1, waited);
        end
        check("frameOverrun", overrun, 0);
        step();
        check("frameDonePulse", frameDone, 0);

        for (int i = 0; i < 2; i++) begin
            lineReq = 1'b1;
            step();
            idleIn();
            step();
        end
        step();
        step();
        check("haltState", {DRAMReadReq, overrun, rowAddress}, FL);

        frameStart = 1'b1;
        step();
        idleIn();
        step();
        DRAMReadAck = 1'b1;
        step();
        idleIn();
        for (int w = 0; w < 10; w++) begin
            DRAMReadValid = 1'b1;
            dataFromDRAM  = 16'(w + 16'h100);
            step();
        end
        check("preResetWr", {outBuffWr1, dataToBuff}, {1'b1, 16'h109});
        #2;
        reset = 1'b1;
        #1;
        check("asyncReset", allOut(), 0);
        idleIn();
        @(negedge CLK100MHz);
        reset = 1'b0;
        step();
        check("postReset", allOut(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_line_reader.md
Name: dram_line_reader

Overview:
- Read-side counterpart of the camera capture path. Fetches stored frame lines back out of DRAM one row at a time.
- Each line is a burst of LINE_PIXELS 16-bit words, written into one of two ping-pong output line buffers (buffer 1 and buffer 2).
- Downstream display/transmit logic reads from the completed buffer while the other one is being filled.
- Row/bank addressing matches the capture writer: one DRAM row per line, bank 0.

Parameters:
- LINE_PIXELS, 640, 16-bit words per line (one DRAM row).
- FRAME_LINES, 480, lines per frame.

Ports:
- CLK100MHz  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- frameStart  in  1  one-cycle pulse: restart the frame at row 0.
- lineReq  in  1  one-cycle pulse from the consumer: it has switched buffers, so fetch the next line.
- DRAMReadAck  in  1  DRAM grants the pending read request.
- DRAMReadValid  in  1  dataFromDRAM carries a valid word this cycle.
- dataFromDRAM  in  16  read data.
- DRAMReadReq  out  1  read request, held high for the whole line transfer.
- rowAddress  out  13  DRAM row of the current or next fetch.
- bankAddress  out  2  DRAM bank; constant 0.
- outBuffWr1  out  1  write strobe for line buffer 1.
- outBuffWr2  out  1  write strobe for line buffer 2.
- dataToBuff  out  16  write data to the line buffers.
- readBuffSelect  out  1  buffer holding the newest complete line (0 = buffer 1, 1 = buffer 2).
- lineReady  out  1  one-cycle pulse when a line completes.
- frameDone  out  1  one-cycle pulse when the last line of the frame completes.
- overrun  out  1  sticky error: a line request was lost.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Internal fill select fillSel = 0, pixelCount = 0, pending = 0, state = IDLE.
- States: IDLE, REQ, READ, DONE, HALT.
- frameStart has highest priority and acts in any state:
  - Next cycle: DRAMReadReq=0, both strobes=0, rowAddress=0, pixelCount=0, pending=0, overrun=0, fillSel=0, readBuffSelect=0.
  - State goes to REQ, so line 0 is prefetched automatically.
- IDLE:
  - If pending=1: clear pending and go to REQ.
  - Else if lineReq=1: go to REQ.
- REQ:
  - DRAMReadReq=1.
  - On DRAMReadAck: go to READ with pixelCount=0. DRAMReadReq stays high.
- READ:
  - Each cycle with DRAMReadValid=1: dataToBuff <= dataFromDRAM; outBuffWr1 <= !fillSel; outBuffWr2 <= fillSel; pixelCount increments.
  - Cycles with DRAMReadValid=0 give strobes=0 next cycle. dataToBuff holds its value.
  - Latency: exactly 1 cycle from valid input to strobe and data.
  - When a valid word arrives with pixelCount == LINE_PIXELS-1: go to DONE and drop DRAMReadReq in the same edge.
- DONE (single cycle):
  - Strobes=0; readBuffSelect <= fillSel; fillSel <= ~fillSel; lineReady pulse; rowAddress increments.
  - If the completed row was FRAME_LINES-1: pulse frameDone and go to HALT. Otherwise go to IDLE.
- HALT: lineReq is ignored (no overrun) until frameStart.
- Ignored inputs:
  - DRAMReadAck outside REQ.
  - DRAMReadValid outside READ; no strobe is generated.
- lineReq while in REQ, READ or DONE:
  - pending=0: set pending=1.
  - pending=1: request is dropped and overrun is set.
- lineReq arriving in IDLE together with pending=1: treated as one queued plus one serviced. Pending stays 1, so the next line is requested right after the current one.
- Widths and counters:
  - pixelCount is 10 bits.
  - rowAddress counts 0..FRAME_LINES and never wraps within a frame.
  - bankAddress is always 0.
- outBuffWr1 and outBuffWr2 are never high together.
- Async reset mid-transfer clears everything immediately. A partially filled buffer is never marked ready.

Test Plan:
- Reset, then frameStart; ack 2 cycles later; 640 valid words with values 0..639 -> 640 outBuffWr1 pulses, each with data equal to the input delayed 1 cycle; DRAMReadReq drops after word 639; lineReady pulse; readBuffSelect=0; rowAddress=1.
- lineReq after line 0 -> line 1 written via outBuffWr2 only; readBuffSelect=1; rowAddress=2; DRAMReadValid gapped every other cycle -> still exactly 640 strobes.
- Two lineReq pulses during a line transfer -> first queued and fetched with no idle gap; second sets overrun=1, which stays high until the next frameStart.
- Run all 480 lines -> frameDone pulses once, in the same cycle as the final lineReady; rowAddress=480; further lineReq gives no DRAMReadReq and no overrun.
- frameStart at word 300 of line 5 -> next cycle DRAMReadReq low, strobes low, rowAddress=0; then REQ reasserts; the following line fills buffer 1.
- Stray DRAMReadAck or DRAMReadValid while in IDLE -> no strobes, no state change; async reset asserted during READ -> all outputs are 0 in the same cycle.
